// File: rtl/module_control_unit.sv
// rtl/module_control_unit.sv - instruction sequencer feeding the ALU and owning the 16x16 register bank
module module_control_unit #(
  parameter int DW      = 16,
  parameter int NREGS   = 16,
  parameter int ALU_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enviar,
  input  logic [17:0]   instr,
  input  logic [DW-1:0] valorGuardarULA,
  output logic [2:0]    opcode,
  output logic          sinalImm,
  output logic [5:0]    Imm,
  output logic [DW-1:0] v1ULA,
  output logic [DW-1:0] v2ULA,
  output logic          busy,
  output logic          disp_valid,
  output logic [3:0]    disp_reg,
  output logic [DW-1:0] disp_val
);

  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;
  localparam logic [3:0] LAST_REG   = 4'(NREGS - 1);
  localparam logic [3:0] EXEC_INIT  = 4'(ALU_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, CLR, SHOW, DONE} state_t;

  state_t        state, state_nx;
  logic          enviar_q;
  logic          start;
  logic [3:0]    cnt;
  logic [3:0]    dst;
  logic [DW-1:0] bank [NREGS];

  // Edges seen outside IDLE are simply dropped; enviar_q tracks the level regardless.
  assign start = enviar & ~enviar_q;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = FETCH;
      FETCH: begin
        if (instr[17:15] == OP_CLEAR)        state_nx = CLR;
        else if (instr[17:15] == OP_DISPLAY) state_nx = SHOW;
        else                                 state_nx = EXEC;
      end
      EXEC:  if (cnt == 4'd0) state_nx = WB;
      WB:    state_nx = DONE;
      CLR:   if (cnt == LAST_REG) state_nx = DONE;
      SHOW:  state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enviar_q   <= 1'b1;
      opcode     <= OP_CLEAR;
      sinalImm   <= 1'b0;
      Imm        <= '0;
      v1ULA      <= '0;
      v2ULA      <= '0;
      cnt        <= '0;
      dst        <= '0;
      disp_valid <= 1'b0;
      disp_reg   <= '0;
      disp_val   <= '0;
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else begin
      enviar_q   <= enviar;
      disp_valid <= 1'b0;
      case (state)
        FETCH: begin
          opcode   <= instr[17:15];
          sinalImm <= instr[6];
          Imm      <= instr[5:0];
          dst      <= instr[14:11];
          // Operands are captured here, so a WB to the same register later cannot disturb them.
          v1ULA    <= bank[instr[10:7]];
          v2ULA    <= bank[instr[6:3]];
          cnt      <= (instr[17:15] == OP_CLEAR) ? 4'd0 : EXEC_INIT;
        end
        EXEC: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        WB: begin
          bank[dst]  <= valorGuardarULA;
          disp_reg   <= dst;
          disp_val   <= valorGuardarULA;
          disp_valid <= 1'b1;
        end
        CLR: begin
          bank[cnt] <= '0;
          cnt       <= cnt + 4'd1;
          if (cnt == LAST_REG) begin
            disp_reg   <= '0;
            disp_val   <= '0;
            disp_valid <= 1'b1;
          end
        end
        SHOW: begin
          disp_reg   <= dst;
          disp_val   <= bank[dst];
          disp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
